// File: rtl/score_disp_pkg.sv
// Shared types and constants for the score display slice.
//   conv_state_t : conversion FSM states (IDLE/SHIFT/COMMIT)
//   BIN_W        : width of the clamped binary score
//   NUM_DIGITS   : number of BCD digits / display positions
//   MAX_SCORE    : largest displayable score
//   SEG_*        : active-low segment patterns {g,f,e,d,c,b,a}
//   seg_decode() : BCD nibble -> segment pattern (blank for >9)
//   clamp_score(): two's complement score -> displayable binary
package score_disp_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } conv_state_t;

  localparam int BIN_W      = 14;
  localparam int NUM_DIGITS = 4;
  localparam int BCD_W      = 4 * NUM_DIGITS;

  localparam logic [BIN_W-1:0] MAX_SCORE = 14'd9999;
  // Index of the final double-dabble iteration.
  localparam logic [3:0]       ITER_LAST = 4'(BIN_W - 1);

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = SEG_0;
      4'd1:    s = SEG_1;
      4'd2:    s = SEG_2;
      4'd3:    s = SEG_3;
      4'd4:    s = SEG_4;
      4'd5:    s = SEG_5;
      4'd6:    s = SEG_6;
      4'd7:    s = SEG_7;
      4'd8:    s = SEG_8;
      4'd9:    s = SEG_9;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  // Negative scores show as 0, anything past 9999 saturates.
  function automatic logic [BIN_W-1:0] clamp_score(input logic [31:0] s);
    logic [BIN_W-1:0] c;
    if (s[31])
      c = '0;
    else if (s > 32'(MAX_SCORE))
      c = MAX_SCORE;
    else
      c = s[BIN_W-1:0];
    return c;
  endfunction

endpackage

// File: rtl/bin2bcd_serial.sv
// Serial double-dabble binary-to-BCD converter.
//   clock, ctrl_reset_n : clock / async active-low reset
//   start               : convert bin (accepted only while idle)
//   bin                 : BIN_W-bit binary value
//   bcd                 : BCD accumulator; final result is valid while done
//   busy                : high from the accept edge until the commit edge
//   done                : one cycle, the COMMIT state
module bin2bcd_serial
  import score_disp_pkg::*;
(
  input  logic             clock,
  input  logic             ctrl_reset_n,
  input  logic             start,
  input  logic [BIN_W-1:0] bin,
  output logic [BCD_W-1:0] bcd,
  output logic             busy,
  output logic             done
);

  conv_state_t      state, state_nxt;
  logic [BIN_W-1:0] bin_sr;
  logic [BCD_W-1:0] bcd_acc;
  logic [BCD_W-1:0] bcd_adj;
  logic [3:0]       iter;

  // Add-3 correction on every nibble that would overflow past 9 once doubled.
  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_adj
    assign bcd_adj[4*g +: 4] = (bcd_acc[4*g +: 4] >= 4'd5) ?
                               bcd_acc[4*g +: 4] + 4'd3 : bcd_acc[4*g +: 4];
  end

  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) state <= IDLE;
    else               state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SHIFT;
      SHIFT:   if (iter == ITER_LAST) state_nxt = COMMIT;
      COMMIT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
    done = (state == COMMIT);
  end

  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      bin_sr  <= '0;
      bcd_acc <= '0;
      iter    <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          bin_sr  <= bin;
          bcd_acc <= '0;
          iter    <= '0;
        end
        SHIFT: begin
          // Top bit of bcd_adj is always 0 for inputs <= 9999.
          {bcd_acc, bin_sr} <= {bcd_adj[BCD_W-2:0], bin_sr, 1'b0};
          iter              <= iter + 4'd1;
        end
        default: ;
      endcase
    end
  end

  assign bcd = bcd_acc;

endmodule

// File: rtl/score_bcd_display.sv
// Score register to 4-digit multiplexed 7-segment display.
//   SCAN_DIV     : cycles each digit stays lit (>= 2)
//   clock        : processor clock
//   ctrl_reset_n : async active-low reset
//   score_in     : 32-bit two's complement score, sampled every cycle
//   bcd_out      : committed BCD value {thousands,hundreds,tens,ones}
//   busy         : conversion in progress
//   seg_n        : active-low segments {g,f,e,d,c,b,a}
//   an_n         : active-low digit enables, bit 0 = ones
module score_bcd_display
  import score_disp_pkg::*;
#(
  parameter int SCAN_DIV = 50000
) (
  input  logic        clock,
  input  logic        ctrl_reset_n,
  input  logic [31:0] score_in,
  output logic [15:0] bcd_out,
  output logic        busy,
  output logic [6:0]  seg_n,
  output logic [3:0]  an_n
);

  localparam int               CNT_W     = $clog2(SCAN_DIV);
  localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_DIV - 1);

  logic [BIN_W-1:0] clamped;
  logic [BIN_W-1:0] last_val;
  logic             start;
  logic             conv_busy;
  logic             conv_done;
  logic [BCD_W-1:0] conv_bcd;

  logic [CNT_W-1:0] scan_cnt;
  logic [1:0]       digit, digit_nxt;
  logic [BCD_W-1:0] bcd_nxt;
  logic [NUM_DIGITS-1:0] lit;
  logic             seen;
  logic [3:0]       nib;
  logic [6:0]       seg_nxt;
  logic [3:0]       an_nxt;

  assign clamped = clamp_score(score_in);
  assign start   = (clamped != last_val);

  // The converter only accepts start while idle, so last_val is latched on
  // the same edge; changes during a conversion are picked up afterwards.
  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n)           last_val <= '0;
    else if (start && !conv_busy) last_val <= clamped;
  end

  bin2bcd_serial u_conv (
    .clock        (clock),
    .ctrl_reset_n (ctrl_reset_n),
    .start        (start),
    .bin          (clamped),
    .bcd          (conv_bcd),
    .busy         (conv_busy),
    .done         (conv_done)
  );

  assign busy = conv_busy;

  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n)  bcd_out <= '0;
    else if (conv_done) bcd_out <= conv_bcd;
  end

  // Scan runs freely; a new bcd_out never restarts it.
  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      scan_cnt <= '0;
      digit    <= '0;
    end else begin
      scan_cnt <= (scan_cnt == SCAN_LAST) ? '0 : scan_cnt + 1'b1;
      digit    <= digit_nxt;
    end
  end

  assign digit_nxt = (scan_cnt == SCAN_LAST) ? digit + 2'd1 : digit;
  assign bcd_nxt   = conv_done ? conv_bcd : bcd_out;

  // A digit is lit if it or any higher digit is non-zero; ones always lit.
  always_comb begin
    lit  = '0;
    seen = 1'b0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      seen   = seen | (bcd_nxt[4*i +: 4] != 4'd0);
      lit[i] = seen | (i == 0);
    end
  end

  // Display registers are fed from the next-cycle digit and value so they
  // change on the same edge as digit / bcd_out.
  always_comb begin
    nib     = bcd_nxt[{digit_nxt, 2'b00} +: 4];
    seg_nxt = lit[digit_nxt] ? seg_decode(nib) : SEG_BLANK;
    an_nxt  = ~(4'b0001 << digit_nxt);
  end

  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      seg_n <= SEG_0;
      an_n  <= 4'b1110;
    end else begin
      seg_n <= seg_nxt;
      an_n  <= an_nxt;
    end
  end

endmodule
